// File: rtl/timer_pkg.sv
// Purpose: bit/field indices shared by the match timer and the capture timer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package timer_pkg;

    // TCR control bits
    localparam int TCR_EN  = 0;
    localparam int TCR_RST = 1;

    // Per-channel CCR field offsets and the width of one channel's field
    localparam int CCR_RISE   = 0;
    localparam int CCR_FALL   = 1;
    localparam int CCR_IRQ    = 2;
    localparam int CCR_STRIDE = 3;

endpackage

// File: rtl/cap_channel.sv
// Purpose: one capture channel: pin synchronizer, edge detect, capture register, sticky irq flag.
// Latency: pin level stable before edge N -> cr/cap_irq update at edge N+SYNC_STAGES.
// Backpressure: none; every qualified edge overwrites cr, flag is set-dominant over clear.
//
// Ports: clk, reset (sync, active-high), cap_in (async pin), ccr (rise/fall/irq enables),
//        irq_clr (write-one-to-clear), tc (live timer count), cr (captured count), cap_irq.
module cap_channel
    import timer_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap_in,
    input  logic [CCR_STRIDE-1:0] ccr,
    input  logic                  irq_clr,
    input  logic [WIDTH-1:0]      tc,
    output logic [WIDTH-1:0]      cr,
    output logic                  cap_irq
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;
    logic                   rise;
    logic                   fall;
    logic                   cap_event;

    assign level     = sync_q[SYNC_STAGES-1];
    assign rise      = level & ~prev_q;
    assign fall      = ~level & prev_q;
    assign cap_event = (rise & ccr[CCR_RISE]) | (fall & ccr[CCR_FALL]);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            cr      <= '0;
            cap_irq <= 1'b0;
        end else begin
            // Synchronizer and prev keep tracking the pin even with both edge enables off,
            // so enabling a channel later does not see a stale edge.
            sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in};
            prev_q <= level;
            if (cap_event) begin
                cr <= tc;   // tc before this edge's increment
            end
            if (cap_event && ccr[CCR_IRQ]) begin
                cap_irq <= 1'b1;   // set wins over a simultaneous clear
            end else if (irq_clr) begin
                cap_irq <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/capture_timer_32.sv
// Purpose: prescaled 32-bit timebase whose count is latched by external capture pins.
// Latency: tc/pc registered (1 clk); capture lands SYNC_STAGES clks after the pin settles.
// Backpressure: none; control inputs are sampled live every cycle.
//
// Ports: clk, reset (sync, active-high), tcr ([0] enable, [1] hold in reset), pr (prescale
//        terminal), ccr (3 bits/channel), cap_in, irq_clr, tc, pc, cr (NUM_CH x WIDTH), cap_irq.
module capture_timer_32
    import timer_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   tcr,
    input  logic [WIDTH-1:0]             pr,
    input  logic [CCR_STRIDE*NUM_CH-1:0] ccr,
    input  logic [NUM_CH-1:0]            cap_in,
    input  logic [NUM_CH-1:0]            irq_clr,
    output logic [WIDTH-1:0]             tc,
    output logic [WIDTH-1:0]             pc,
    output logic [NUM_CH*WIDTH-1:0]      cr,
    output logic [NUM_CH-1:0]            cap_irq
);

    // tcr[7:2] are reserved
    logic unused_tcr;
    assign unused_tcr = ^tcr[7:2];

    // If pr is lowered below pc, the equality never hits and pc wraps through 2^WIDTH.
    always_ff @(posedge clk) begin
        if (reset || tcr[TCR_RST]) begin
            tc <= '0;
            pc <= '0;
        end else if (tcr[TCR_EN]) begin
            if (pc == pr) begin
                pc <= '0;
                tc <= tc + 1'b1;
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        cap_channel #(
            .WIDTH      (WIDTH),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .cap_in (cap_in[n]),
            .ccr    (ccr[n*CCR_STRIDE +: CCR_STRIDE]),
            .irq_clr(irq_clr[n]),
            .tc     (tc),
            .cr     (cr[n*WIDTH +: WIDTH]),
            .cap_irq(cap_irq[n])
        );
    end

endmodule

// File: tb/tb_capture_timer_32.sv
module tb_capture_timer_32;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   tcr;
    logic [31:0]  pr;
    logic [11:0]  ccr;
    logic [3:0]   cap_in;
    logic [3:0]   irq_clr;
    logic [31:0]  tc, pc;
    logic [127:0] cr;
    logic [3:0]   cap_irq;

    // Narrow instance used to reach the wrap boundaries in a short run
    logic [7:0]   pr8;
    logic [2:0]   ccr8;
    logic [0:0]   cap_in8, irq_clr8, cap_irq8;
    logic [7:0]   tc8, pc8, cr8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    capture_timer_32 dut (
        .clk(clk), .reset(reset), .tcr(tcr), .pr(pr), .ccr(ccr), .cap_in(cap_in),
        .irq_clr(irq_clr), .tc(tc), .pc(pc), .cr(cr), .cap_irq(cap_irq)
    );

    capture_timer_32 #(.WIDTH(8), .NUM_CH(1), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .tcr(tcr), .pr(pr8), .ccr(ccr8), .cap_in(cap_in8),
        .irq_clr(irq_clr8), .tc(tc8), .pc(pc8), .cr(cr8), .cap_irq(cap_irq8)
    );

    // ---------------- reference model ----------------
    // Pin history: hist[k] = cap_in sampled k+1 edges ago. An edge seen at the
    // synchronizer output compares the samples two and three edges back.
    logic [31:0] m_tc, m_pc;
    logic [31:0] m_cr [4];
    logic [3:0]  m_irq;
    logic [3:0]  hist [3];

    task automatic model_clear();
        m_tc = 0; m_pc = 0; m_irq = 0;
        for (int n = 0; n < 4; n++) m_cr[n] = 0;
        for (int k = 0; k < 3; k++) hist[k] = 0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_clear();
        end else begin
            for (int n = 0; n < 4; n++) begin
                bit now_hi, was_hi, ev;
                now_hi = hist[1][n];
                was_hi = hist[2][n];
                ev = (now_hi && !was_hi && ccr[3*n]) || (!now_hi && was_hi && ccr[3*n+1]);
                if (ev) m_cr[n] = m_tc;
                if (ev && ccr[3*n+2]) m_irq[n] = 1'b1;
                else if (irq_clr[n])  m_irq[n] = 1'b0;
            end
            if (tcr[1]) begin
                m_tc = 0; m_pc = 0;
            end else if (tcr[0]) begin
                if (m_pc == pr) begin m_pc = 0; m_tc = m_tc + 1; end
                else m_pc = m_pc + 1;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = cap_in;
        end
    endtask

    // One clock: model follows the edge, bench resumes at the falling edge.
    task automatic step(input int cycles = 1);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tcr = 8'($urandom); pr = $urandom; ccr = 12'($urandom);
        cap_in = 4'($urandom); irq_clr = 4'($urandom);
        reset = 1'b1;
        step(2);
        if (tc !== 32'd0 || pc !== 32'd0) begin
            errors++; $display("FAIL reset_tb tc=%h pc=%h want 0/0", tc, pc);
        end
        checks++;
        if (cr !== 128'd0 || cap_irq !== 4'd0) begin
            errors++; $display("FAIL reset_cap cr=%h irq=%b want 0/0", cr, cap_irq);
        end
        checks++;
        if (tc8 !== 8'd0 || cr8 !== 8'd0) begin
            errors++; $display("FAIL reset_narrow tc8=%h cr8=%h want 0/0", tc8, cr8);
        end
        checks++;
    endtask

    task automatic test_timebase();
        reset = 1'b1; tcr = 8'h01; pr = 32'd3; ccr = 0; cap_in = 0; irq_clr = 0;
        step(1);
        reset = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            step(1);
            // tc advances once per 4 enabled clocks
            if (tc !== 32'(c / 4) || pc !== 32'(c % 4)) begin
                errors++; $display("FAIL prescale c=%0d tc=%0d pc=%0d want %0d/%0d", c, tc, pc, c / 4, c % 4);
            end
            checks++;
        end
        tcr = 8'hFC;   // enable clear, reserved bits set: must hold
        step(3);
        if (tc !== 32'd3 || pc !== 32'd1) begin
            errors++; $display("FAIL hold tc=%0d pc=%0d want 3/1", tc, pc);
        end
        checks++;
    endtask

    task automatic test_wrap8();
        logic [7:0] exp_tc;
        reset = 1'b1; tcr = 8'h01; pr8 = 8'd0;
        step(1);
        reset = 1'b0;
        step(255);
        if (tc8 !== 8'd255) begin
            errors++; $display("FAIL wrap_pre tc8=%0d want 255", tc8);
        end
        checks++;
        step(1);
        exp_tc = 8'd0;
        if (tc8 !== exp_tc || pc8 !== 8'd0) begin
            errors++; $display("FAIL wrap tc8=%0d pc8=%0d want 0/0", tc8, pc8);
        end
        checks++;
        // pr lowered below pc: pc runs on through 255 and wraps without a tc tick
        pr8 = 8'd200;
        step(10);
        pr8 = 8'd3;
        step(246);
        if (pc8 !== 8'd0 || tc8 !== 8'd0) begin
            errors++; $display("FAIL pc_wrap pc8=%0d tc8=%0d want 0/0", pc8, tc8);
        end
        checks++;
        step(4);
        if (tc8 !== 8'd1 || pc8 !== 8'd0) begin
            errors++; $display("FAIL pc_wrap_resume tc8=%0d pc8=%0d want 1/0", tc8, pc8);
        end
        checks++;
    endtask

    task automatic test_capture_rise();
        reset = 1'b1; tcr = 8'h01; pr = 0; ccr = 12'b000_000_000_101; cap_in = 0; irq_clr = 0;
        step(1);
        reset = 1'b0;
        step(10);
        if (tc !== 32'd10) begin
            errors++; $display("FAIL rise_setup tc=%0d want 10", tc);
        end
        checks++;
        cap_in[0] = 1'b1;
        step(2);
        if (cr[31:0] !== 32'd0 || cap_irq[0] !== 1'b0) begin
            errors++; $display("FAIL rise_early cr0=%0d irq=%b want 0/0", cr[31:0], cap_irq[0]);
        end
        checks++;
        step(1);
        if (cr[31:0] !== 32'd12 || cap_irq[0] !== 1'b1) begin
            errors++; $display("FAIL rise_cap cr0=%0d irq=%b want 12/1", cr[31:0], cap_irq[0]);
        end
        checks++;
    endtask

    task automatic test_fall_only();
        logic [31:0] exp_cr;
        ccr[5:3] = 3'b010;
        cap_in[1] = 1'b1;
        step(4);
        if (cr[63:32] !== 32'd0 || cap_irq[1] !== 1'b0) begin
            errors++; $display("FAIL fall_ignores_rise cr1=%0d irq=%b want 0/0", cr[63:32], cap_irq[1]);
        end
        checks++;
        exp_cr = tc + 2;
        cap_in[1] = 1'b0;
        step(3);
        if (cr[63:32] !== exp_cr || cap_irq[1] !== 1'b0) begin
            errors++; $display("FAIL fall_cap cr1=%0d irq=%b want %0d/0", cr[63:32], cap_irq[1], exp_cr);
        end
        checks++;
    endtask

    task automatic test_irq_clr();
        logic [31:0] exp_cr;
        ccr[2:0] = 3'b111;
        exp_cr = tc + 2;
        cap_in[0] = 1'b0;
        step(2);
        irq_clr[0] = 1'b1;   // clear coincides with the capture edge
        step(1);
        irq_clr[0] = 1'b0;
        if (cap_irq[0] !== 1'b1 || cr[31:0] !== exp_cr) begin
            errors++; $display("FAIL set_beats_clr irq=%b cr0=%0d want 1/%0d", cap_irq[0], cr[31:0], exp_cr);
        end
        checks++;
        irq_clr[0] = 1'b1;
        step(1);
        irq_clr[0] = 1'b0;
        if (cap_irq[0] !== 1'b0) begin
            errors++; $display("FAIL clr irq=%b want 0", cap_irq[0]);
        end
        checks++;
    endtask

    task automatic test_held();
        ccr[8:6] = 3'b011;
        cap_in[2] = 1'b1;
        step(3);
        if (cr[95:64] === 32'd0) begin
            errors++; $display("FAIL held_setup cr2=%0d want nonzero", cr[95:64]);
        end
        checks++;
        tcr = 8'h02;
        step(2);
        cap_in[2] = 1'b0;
        step(3);
        if (cr[95:64] !== 32'd0 || tc !== 32'd0) begin
            errors++; $display("FAIL held_cap cr2=%0d tc=%0d want 0/0", cr[95:64], tc);
        end
        checks++;
        // Edge in flight through the synchronizer is dropped by reset
        tcr = 8'h01;
        step(5);
        cap_in[2] = 1'b1;
        step(1);
        reset = 1'b1;
        cap_in[2] = 1'b0;
        step(1);
        reset = 1'b0;
        step(5);
        if (cr[95:64] !== 32'd0 || cap_irq !== 4'd0 || tc !== 32'd5) begin
            errors++; $display("FAIL reset_midsync cr2=%0d irq=%b tc=%0d want 0/0/5", cr[95:64], cap_irq, tc);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) reset = 1'b1; else reset = 1'b0;
            if ($urandom_range(0, 39) == 0) ccr = 12'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 4))
                    0: tcr = 8'h00;
                    1: tcr = 8'h02;
                    default: tcr = 8'h01 | 8'($urandom_range(0, 63) << 2);
                endcase
            end
            if ($urandom_range(0, 49) == 0) pr = $urandom_range(0, 3);
            for (int n = 0; n < 4; n++)
                if ($urandom_range(0, 5) == 0) cap_in[n] = ~cap_in[n];
            irq_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            step(1);
            if (tc !== m_tc || pc !== m_pc) begin
                errors++; $display("FAIL rand_timebase c=%0d tc=%h pc=%h want %h/%h", c, tc, pc, m_tc, m_pc);
            end
            checks++;
            for (int n = 0; n < 4; n++) begin
                if (cr[n*32 +: 32] !== m_cr[n] || cap_irq[n] !== m_irq[n]) begin
                    errors++;
                    $display("FAIL rand_cap c=%0d ch=%0d cr=%h irq=%b want %h/%b",
                             c, n, cr[n*32 +: 32], cap_irq[n], m_cr[n], m_irq[n]);
                end
                checks++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; tcr = 0; pr = 0; ccr = 0; cap_in = 0; irq_clr = 0;
        pr8 = 0; ccr8 = 3'b111; cap_in8 = 0; irq_clr8 = 0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_timebase();
        test_wrap8();
        test_capture_rise();
        test_fall_only();
        test_irq_clr();
        test_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
